// File: rtl/definitions_pkg.sv
// Shared widths and the packed {mag, dir} pixel used by the gradient window buffer.
package definitions_pkg;
  localparam int MAG_W    = 11;
  localparam int DIR_W    = 2;
  localparam int WIN_SIZE = 9;
  localparam int PIX_W    = MAG_W + DIR_W;

  typedef struct packed {
    logic [MAG_W-1:0] mag;
    logic [DIR_W-1:0] dir;
  } pixel_t;
endpackage

// File: rtl/gradient_window_buffer_if.sv
// Pixel stream in, 3x3 window out; the slave modport is the buffer's view.
interface gradient_window_buffer_if;
  import definitions_pkg::*;

  logic [MAG_W-1:0]          grad_mag;
  logic [DIR_W-1:0]          grad_dir;
  logic                      grad_valid;
  logic [MAG_W*WIN_SIZE-1:0] gradient_magnitude;
  logic [DIR_W*WIN_SIZE-1:0] gradient_direction;
  logic                      gradient_data_valid;

  modport master (
    output grad_mag, grad_dir, grad_valid,
    input  gradient_magnitude, gradient_direction, gradient_data_valid
  );

  modport slave (
    input  grad_mag, grad_dir, grad_valid,
    output gradient_magnitude, gradient_direction, gradient_data_valid
  );
endinterface

// File: rtl/line_buffer.sv
// One-line delay memory: combinational read and registered write at the same
// address, so a read in the write cycle returns the previous line's value.
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 13,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Contents are deliberately not reset; two full lines overwrite them first.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end
endmodule

// File: rtl/gradient_window_buffer.sv
// Builds a 3x3 {magnitude, direction} window from a raster gradient stream,
// flagging only windows whose centre is an interior pixel.
module gradient_window_buffer
  import definitions_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic                     clk,
  input logic                     rst_n,
  gradient_window_buffer_if.slave bus
);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  pixel_t           in_pix;
  pixel_t           lb1_rd;
  pixel_t           lb2_rd;
  pixel_t           win [WIN_SIZE];
  logic             data_valid;
  logic [MAG_W*WIN_SIZE-1:0] mag_flat;
  logic [DIR_W*WIN_SIZE-1:0] dir_flat;

  assign in_pix.mag = bus.grad_mag;
  assign in_pix.dir = bus.grad_dir;

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) u_line1 (
    .clk     (clk),
    .we      (bus.grad_valid),
    .addr    (col),
    .wr_data (in_pix),
    .rd_data (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) u_line2 (
    .clk     (clk),
    .we      (bus.grad_valid),
    .addr    (col),
    .wr_data (lb1_rd),
    .rd_data (lb2_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (bus.grad_valid) begin
      if (col == COL_W'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stale columns from the previous line or frame are masked by the col/row gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN_SIZE; k++) begin
        win[k] <= '0;
      end
      data_valid <= 1'b0;
    end else begin
      data_valid <= bus.grad_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      if (bus.grad_valid) begin
        win[2] <= win[1];
        win[1] <= win[0];
        win[0] <= in_pix;
        win[5] <= win[4];
        win[4] <= win[3];
        win[3] <= lb1_rd;
        win[8] <= win[7];
        win[7] <= win[6];
        win[6] <= lb2_rd;
      end
    end
  end

  always_comb begin
    mag_flat = '0;
    dir_flat = '0;
    for (int k = 0; k < WIN_SIZE; k++) begin
      mag_flat[MAG_W*k +: MAG_W] = win[k].mag;
      dir_flat[DIR_W*k +: DIR_W] = win[k].dir;
    end
  end

  assign bus.gradient_magnitude  = mag_flat;
  assign bus.gradient_direction  = dir_flat;
  assign bus.gradient_data_valid = data_valid;
endmodule

// File: tb/tb_gradient_window_buffer.sv
// Drives ramp and random frames (with random gaps and a mid-frame reset) and
// compares every cycle against an image-array model of the 3x3 window.
module tb_gradient_window_buffer;
  localparam int W = 8;
  localparam int H = 6;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   frame_valids;
  int   all_valids;
  int   mrow;
  int   mcol;
  bit   held_known;
  bit   ramp_mode;
  logic [10:0] img_mag [H][W];
  logic [1:0]  img_dir [H][W];
  logic [98:0] exp_mag;
  logic [17:0] exp_dir;

  gradient_window_buffer_if gif ();

  gradient_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [98:0] obs, input logic [98:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_output(input logic exp_valid, input bit check_win);
    check_value("valid", 99'(gif.gradient_data_valid), 99'(exp_valid));
    if (check_win) begin
      check_value("mag_window", gif.gradient_magnitude, exp_mag);
      check_value("dir_window", 99'(gif.gradient_direction), 99'(exp_dir));
    end
  endtask

  task automatic check_first_window();
    logic [98:0] m;
    logic [17:0] d;
    m = gif.gradient_magnitude;
    d = gif.gradient_direction;
    check_value("first_slot0", 99'(m[10:0]), 99'(18));
    check_value("first_slot2", 99'(m[32:22]), 99'(16));
    check_value("first_slot4", 99'(m[54:44]), 99'(9));
    check_value("first_slot6", 99'(m[76:66]), 99'(2));
    check_value("first_slot8", 99'(m[98:88]), 99'(0));
    check_value("first_dir4", 99'(d[9:8]), 99'(1));
  endtask

  task automatic apply_stimulus(input logic v, input logic [10:0] m, input logic [1:0] d);
    logic ev;
    @(negedge clk);
    gif.grad_valid = v;
    gif.grad_mag   = m;
    gif.grad_dir   = d;
    @(posedge clk);
    #1;
    if (gif.gradient_data_valid === 1'b1) begin
      frame_valids++;
      all_valids++;
    end
    if (v) begin
      img_mag[mrow][mcol] = m;
      img_dir[mrow][mcol] = d;
      ev = (mrow >= 2) && (mcol >= 2);
      if (ev) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            exp_mag[11*(3*r+c) +: 11] = img_mag[mrow-r][mcol-c];
            exp_dir[2*(3*r+c) +: 2]   = img_dir[mrow-r][mcol-c];
          end
        end
      end
      check_output(ev, ev);
      if (ramp_mode && mrow == 2 && mcol == 2) begin
        check_first_window();
      end
      held_known = ev;
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end
    end else begin
      check_output(1'b0, held_known);
    end
  endtask

  task automatic send_frame(input int gap_pct, input bit ramp, input int npix);
    logic [10:0] m;
    logic [1:0]  d;
    ramp_mode = ramp;
    frame_valids = 0;
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        apply_stimulus(1'b0, 11'($urandom), 2'($urandom));
      end
      if (ramp) begin
        m = 11'(mrow * 8 + mcol);
        d = 2'(mcol % 4);
      end else begin
        m = 11'($urandom);
        d = 2'($urandom);
      end
      apply_stimulus(1'b1, m, d);
    end
  endtask

  task automatic check_reset_outputs();
    check_value("rst_valid", 99'(gif.gradient_data_valid), 99'(0));
    check_value("rst_mag", gif.gradient_magnitude, 99'(0));
    check_value("rst_dir", 99'(gif.gradient_direction), 99'(0));
  endtask

  initial begin
    total = 0;
    bad = 0;
    all_valids = 0;
    frame_valids = 0;
    mrow = 0;
    mcol = 0;
    held_known = 1'b0;
    ramp_mode = 1'b0;
    exp_mag = '0;
    exp_dir = '0;
    rst_n = 1'b0;
    gif.grad_valid = 1'b0;
    gif.grad_mag = '0;
    gif.grad_dir = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    send_frame(0, 1'b1, W * H);
    check_value("frame1_count", 99'(frame_valids), 99'(24));

    send_frame(50, 1'b1, W * H);
    check_value("frame2_count", 99'(frame_valids), 99'(24));
    check_value("two_frame_count", 99'(all_valids), 99'(48));

    send_frame(0, 1'b0, W * H);
    check_value("frame3_count", 99'(frame_valids), 99'(24));

    send_frame(0, 1'b1, 30);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    mrow = 0;
    mcol = 0;
    held_known = 1'b0;
    gif.grad_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    send_frame(30, 1'b1, W * H);
    check_value("post_reset_count", 99'(frame_valids), 99'(24));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gradient_window_buffer.md
GRADIENT_WINDOW_BUFFER -- requirements
Module: gradient_window_buffer

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (legal range 3..4096).
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame (legal range 3..4096).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 grad_mag  input  11  gradient magnitude of the incoming pixel (raster order).
REQ-006 grad_dir  input  2  quantised gradient direction of the incoming pixel.
REQ-007 grad_valid  input  1  pixel strobe; one pixel is accepted per cycle while high, with no backpressure.
REQ-008 gradient_magnitude  output  99  3x3 magnitude window; slot k occupies bits [11k+10:11k].
REQ-009 gradient_direction  output  18  3x3 direction window; slot k occupies bits [2k+1:2k].
REQ-010 gradient_data_valid  output  1  window valid strobe to the NMS stage.

Function
REQ-011 Slot k = 3*r + c; r = 0 is the current line, r = 2 is two lines up; c = 0 is the newest column, c = 2 is two columns back; slot 4 is the centre.
REQ-012 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) advance only on accepted pixels.
REQ-013 col wraps to 0 after IMG_WIDTH-1 and increments row; row wraps to 0 after IMG_HEIGHT-1, so the frame restarts at (0,0) with no idle cycle required.
REQ-014 Two line buffers of IMG_WIDTH x 13 bits ({mag,dir}) are indexed by col: line buffer 1 supplies row-1 and line buffer 2 supplies row-2.
REQ-015 On an accepted pixel: read both buffers at col, write the input to buffer 1 at col, and write the buffer-1 read data to buffer 2 at col.
REQ-016 On an accepted pixel, each window row shifts c0->c1->c2; new c0 = input (r0), buffer-1 data (r1), buffer-2 data (r2).
REQ-017 gradient_data_valid SHALL be 1 for exactly one cycle, the cycle after an accepted pixel with row >= 2 and col >= 2, and 0 otherwise.
REQ-018 Latency: 1 cycle from the accepted pixel to the registered window outputs; the window centre is pixel (row-1, col-1).
REQ-019 Border pixels produce no output: each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid windows.
REQ-020 When grad_valid = 0: counters, window and buffers hold, and gradient_data_valid = 0.
REQ-021 Window outputs hold their last value while invalid; downstream samples them only when valid.
REQ-022 Window columns left over from the previous line or frame are never flagged valid, because col >= 2 and row >= 2 gate validity.

Reset
REQ-023 Assertion of rst_n clears col, row, all window registers, gradient_magnitude, gradient_direction and gradient_data_valid to 0, asynchronously.
REQ-024 Line-buffer contents are not reset; after reset, rows 0-1 rewrite them before any valid window is produced.
REQ-025 A reset mid-frame abandons the frame; the first pixel accepted after deassertion is (0,0).

Structure
REQ-026 definitions_pkg SHALL hold MAG_W = 11, DIR_W = 2, WIN_SIZE = 9, and a packed pixel typedef {mag, dir}.
REQ-027 One sub-module, line_buffer (parameterised depth and width, one read and one write per cycle at the same address, read-before-write), is instantiated twice.

Verification (IMG_WIDTH = 8, IMG_HEIGHT = 6)
REQ-028 Reset with grad_valid = 0 -> all outputs 0; counters at (0,0).
REQ-029 Ramp stimulus mag = row*8 + col, dir = col%4, continuous -> first valid is the cycle after pixel 18, with slot0 = 18, slot4 = 9, slot8 = 0, slot2 = 16, slot6 = 2, and direction slot4 = 1.
REQ-030 Full frame -> exactly 24 valid pulses, none for col < 2 or row < 2.
REQ-031 Same ramp with random grad_valid gaps (around 50%) -> identical window sequence to REQ-029/030, with valid never high during a gap cycle.
REQ-032 Two back-to-back frames -> second frame's first valid follows its pixel 18 and has slot4 = 9 of the new frame; 48 valid pulses total.
REQ-033 rst_n pulsed at pixel 30, then ramp restarted -> no valid until the new pixel 18; windows match REQ-029.
